inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
Front-end fetch stage between the system bus and the instruction decoder. Issues 64-byte line reads (8 beats of 64 bits) at the current fetch PC. Splits each beat into two 32-bit instructions and queues them with their PCs in a FIFO. Hands instructions one at a time to the decode stage over a valid/ready handshake, and supports redirect (branch/jump) and halt on an all-zero instruction word.

Parameters:
BUS_DATA_WIDTH, 64, bus data width; fixed at 64, two instructions per beat.
BUS_TAG_WIDTH, 13, bus tag width.
LINE_BEATS, 8, beats per line request; line size is LINE_BEATS*8 bytes.
FIFO_DEPTH, 32, instruction FIFO entries; power of 2, at least 2*LINE_BEATS.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
entry  in  64  program entry point, sampled while reset is asserted.
bus_reqcyc  out  1  request valid.
bus_req  out  64  request address, line-aligned.
bus_reqtag  out  BUS_TAG_WIDTH  request tag, constant `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8.
bus_reqack  in  1  request accepted.
bus_respcyc  in  1  response beat valid.
bus_respack  out  1  response beat accepted.
bus_resp  in  64  response data; [31:0] is the lower-address instruction.
bus_resptag  in  BUS_TAG_WIDTH  response tag; ignored unless the optional feature is enabled.
redirect_valid  in  1  flush and restart fetch.
redirect_pc  in  64  new PC, 4-byte aligned.
inst_valid  out  1  FIFO head valid.
inst_ready  in  1  decoder accepts head.
inst  out  32  head instruction.
inst_pc  out  64  head instruction address.
halt  out  1  end-of-program reached and FIFO drained.

Behaviour:
- Reset (async, active-low) values:
  - Outputs: bus_reqcyc=0, bus_req=0, bus_respack=0, inst_valid=0, halt=0.
  - Internal: FIFO empty, fetch_pc={entry[63:6],6'b0}, skip=entry[5:2], state IDLE, drop=0, halt_seen=0.
- IDLE:
  - If halt_seen, go to HALT.
  - Else if FIFO free entries >= 2*LINE_BEATS, go to REQ next cycle. Otherwise stay in IDLE.
- REQ:
  - bus_reqcyc=1 and bus_req=fetch_pc, held stable until bus_reqack is sampled high.
  - On ack: clear beat counter, go to RESP.
- RESP:
  - bus_respack = bus_respcyc, combinational and same cycle; every beat is accepted.
  - Per beat, unless drop=1: first the low word at PC fetch_pc+8*beat, then the high word at that PC +4.
    - A word is discarded while skip>0; skip decrements per word.
    - An all-zero word sets halt_seen. That word and every later word in the line are discarded.
  - After beat LINE_BEATS-1: fetch_pc += 64 (wraps modulo 2^64), drop clears, go to IDLE.
- HALT:
  - No requests issued.
  - halt=1 when FIFO is empty.
  - Leaves only on redirect or reset.
- Output side:
  - inst_valid = FIFO not empty; inst and inst_pc come from the head.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle are both allowed. FIFO never overflows, guaranteed by the IDLE space check.
- Redirect (redirect_valid=1), same cycle:
  - FIFO flushes, halt_seen and halt clear.
  - fetch_pc={redirect_pc[63:6],6'b0}, skip=redirect_pc[5:2].
  - A pop in the same cycle is ignored; redirect wins.
  - In IDLE or HALT: go to IDLE.
  - In REQ: request stays stable until ack; then drop=1 and the whole line is acked and discarded.
  - In RESP: drop=1; remaining beats are acked and discarded.
  - After the dropped line, the new line is fetched. The dropped line does not advance fetch_pc.
  - A second redirect overrides the first.
- Reset mid-transaction: all state clears immediately. The bus side is assumed to be reset together with this block.

Optional Feature:
FETCH_TRACE_EN
- Defined: every accepted pop prints "%h: %h" (inst_pc, inst) via $display, and halt assertion prints "fetch halt".
- Undefined: no simulation output; the RTL is otherwise identical.

Test Plan:
1. entry=0x1000, line of 16 nonzero words, inst_ready=1 -> request at 0x1000; 16 instructions out with PCs 0x1000..0x103C in order; second request at 0x1040.
2. entry=0x1008 -> request at 0x1000; first inst_pc=0x1008; 14 instructions queued.
3. Word 5 of line is 0 -> 5 instructions delivered; remaining beats acked; no further request; halt=1 once drained.
4. inst_ready=0 with FIFO_DEPTH=32 -> two lines fetched, no third request until at least 16 entries are free; FIFO contents intact.
5. redirect_pc=0x2004 asserted during beat 3 -> beats 4-7 acked and dropped; FIFO empty; next request 0x2000; first inst_pc=0x2004.
6. redirect_valid in REQ before ack -> bus_req unchanged until ack; whole line dropped; then request at the redirect line.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: line reads from the system bus, split into 32-bit instructions,
// queued with their PCs and handed to decode. Optional trace: FETCH_TRACE_EN.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module inst_fetch_buffer #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned LINE_BEATS     = 8,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc,
  output logic                      halt
);

  localparam int unsigned BEAT_W     = $clog2(LINE_BEATS);
  localparam int unsigned OFF_W      = BEAT_W + 3;
  localparam int unsigned SKIP_W     = OFF_W - 2;
  localparam int unsigned LINE_BYTES = LINE_BEATS * 8;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [63:0]       fetch_pc;
  logic [SKIP_W-1:0] skip, skip_nxt;
  logic              drop, halt_seen, seen_nxt;
  logic [BEAT_W-1:0] beat;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [63:0]       fifo_pc   [FIFO_DEPTH];

  logic              beat_fire, last_beat, space_ok, pop;
  logic              push_lo, push_hi;
  logic [1:0]        push_n;
  logic [63:0]       pc_lo, pc_hi;
  logic              unused_inputs;

  assign bus_reqtag  = BUS_TAG_WIDTH'((`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8));
  assign bus_respack = (state == S_RESP) && bus_respcyc;
  assign beat_fire   = bus_respack;
  assign last_beat   = beat_fire && (beat == BEAT_W'(LINE_BEATS - 1));
  assign space_ok    = count <= CNT_W'(FIFO_DEPTH - 2 * LINE_BEATS);
  assign inst_valid  = count != '0;
  assign inst        = fifo_inst[rd_ptr];
  assign inst_pc     = fifo_pc[rd_ptr];
  assign halt        = (state == S_HALT) && (count == '0);
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign pc_lo       = {fetch_pc[63:OFF_W], beat, 3'b000};
  assign pc_hi       = {fetch_pc[63:OFF_W], beat, 3'b100};
  assign push_n      = 2'(push_lo) + 2'(push_hi);
  assign unused_inputs = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

  // Per-word filter: skip leading words, stop the line at the first zero word.
  always_comb begin
    skip_nxt = skip;
    seen_nxt = halt_seen;
    push_lo  = 1'b0;
    push_hi  = 1'b0;
    if (beat_fire && !drop && !halt_seen) begin
      if (skip_nxt != '0)             skip_nxt = skip_nxt - SKIP_W'(1);
      else if (bus_resp[31:0] == '0)  seen_nxt = 1'b1;
      else                            push_lo  = 1'b1;
      if (!seen_nxt) begin
        if (skip_nxt != '0)            skip_nxt = skip_nxt - SKIP_W'(1);
        else if (bus_resp[63:32] == '0) seen_nxt = 1'b1;
        else                            push_hi  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (redirect_valid)  state_nxt = S_IDLE;
        else if (halt_seen)  state_nxt = S_HALT;
        else if (space_ok)   state_nxt = S_REQ;
      end
      S_REQ:   if (bus_reqack)     state_nxt = S_RESP;
      S_RESP:  if (last_beat)      state_nxt = S_IDLE;
      S_HALT:  if (redirect_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch bookkeeping and FIFO pointers; a redirect overrides everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= {entry[63:OFF_W], OFF_W'(0)};
      skip       <= entry[OFF_W-1:2];
      drop       <= 1'b0;
      halt_seen  <= 1'b0;
      beat       <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      bus_reqcyc <= (state_nxt == S_REQ);
      if ((state == S_IDLE) && (state_nxt == S_REQ)) bus_req <= fetch_pc;
      if ((state == S_REQ) && bus_reqack) beat <= '0;
      else if (beat_fire)                 beat <= beat + BEAT_W'(1);
      if (redirect_valid) begin
        fetch_pc  <= {redirect_pc[63:OFF_W], OFF_W'(0)};
        skip      <= redirect_pc[OFF_W-1:2];
        halt_seen <= 1'b0;
        drop      <= ((state == S_REQ) || (state == S_RESP)) && !last_beat;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
      end else begin
        skip      <= skip_nxt;
        halt_seen <= seen_nxt;
        if (last_beat) begin
          drop <= 1'b0;
          if (!drop) fetch_pc <= fetch_pc + 64'(LINE_BYTES);
        end
        wr_ptr <= wr_ptr + PTR_W'(push_n);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        count  <= count + CNT_W'(push_n) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_lo) begin
      fifo_inst[wr_ptr] <= bus_resp[31:0];
      fifo_pc[wr_ptr]   <= pc_lo;
    end
    if (push_hi) begin
      fifo_inst[wr_ptr + PTR_W'(push_lo)] <= bus_resp[63:32];
      fifo_pc[wr_ptr + PTR_W'(push_lo)]   <= pc_hi;
    end
  end

`ifdef FETCH_TRACE_EN
  logic halt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt;
      if (pop) $display("%h: %h", inst_pc, inst);
      if (halt && !halt_q) $display("fetch halt");
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer: bus responder plus a line-level
// reference model of the instruction stream, checked every cycle.

module tb_inst_fetch_buffer;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned BEATS = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        halt;

  always #5 clk = ~clk;

  inst_fetch_buffer dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .halt(halt)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory image
  logic [63:0] zero_addr;
  logic [31:0] salt;

  // Reference model
  ent_t        q[$];
  logic [63:0] m_pc;
  logic [3:0]  m_skip;
  bit          m_halt, line_drop, in_line, req_active;
  logic [63:0] req_addr;

  // Responder and stimulus controls
  logic [63:0] rsp_q[$];
  int          rsp_beat;
  int          ready_mode;
  bit          ack_block, trig_b3, rand_redir, redir_now;
  logic [63:0] trig_pc, redir_pc_now;

  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return {4'hA, a[29:2] ^ salt[27:0]};
  endfunction

  function automatic logic [63:0] at(input logic [63:0] qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return 'x;
  endfunction

  // Whole-line view of what the fetch stage must queue for a line at a.
  task automatic append_line(input logic [63:0] a);
    logic [31:0] w;
    for (int i = 0; i < 2 * BEATS; i++) begin
      if (m_halt) break;
      w = mem_word(a + 64'(4 * i));
      if (m_skip != 0)   m_skip = m_skip - 4'd1;
      else if (w == 0)   m_halt = 1'b1;
      else               q.push_back('{pc: a + 64'(4 * i), ins: w});
    end
  endtask

  task automatic step();
    logic [63:0] a;
    @(negedge clk);
    inst_ready  = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
    bus_reqack  = bus_reqcyc && !ack_block && ($urandom_range(0, 2) == 0);
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    if (rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      bus_respcyc = 1'b1;
      a = rsp_q[0] + 64'(rsp_beat * 8);
      bus_resp = {mem_word(a + 64'd4), mem_word(a)};
    end
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_pc_now;
      redir_now      = 1'b0;
    end else if (trig_b3 && bus_respcyc && rsp_beat == 3) begin
      redirect_valid = 1'b1;
      redirect_pc    = trig_pc;
      trig_b3        = 1'b0;
    end else if (rand_redir && $urandom_range(0, 99) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = 64'($urandom_range(0, 32'hFFFFF)) << 2;
      if ($urandom_range(0, 3) == 0)
        zero_addr = {redirect_pc[63:6], 6'b0} + 64'(4 * $urandom_range(0, 40));
    end
    #1;
    // request address, tag, stability, and issue conditions
    if (bus_reqcyc) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_addr   = bus_req;
        req_log.push_back(bus_req);
        chk("req_addr", bus_req, m_pc);
        chk("req_tag", 64'(bus_reqtag), 64'h1100);
        chk("req_not_halted", 64'(m_halt), 64'd0);
        chk("req_space", 64'(q.size() <= DEPTH - 2 * BEATS), 64'd1);
      end else begin
        chk("req_stable", bus_req, req_addr);
      end
    end
    if (halt) chk("halt_cond", 64'(m_halt && q.size() == 0), 64'd1);
    if (q.size() == 0) chk("valid_with_empty_model", 64'(inst_valid), 64'd0);
    if (inst_valid && inst_ready && !redirect_valid && q.size() > 0) begin
      ent_t e;
      e = q.pop_front();
      chk("inst_pc", inst_pc, e.pc);
      chk("inst", 64'(inst), 64'(e.ins));
      pop_log.push_back(inst_pc);
    end
    if (redirect_valid) begin
      q.delete();
      m_halt = 1'b0;
      m_pc   = {redirect_pc[63:6], 6'b0};
      m_skip = redirect_pc[5:2];
      if (bus_reqcyc || in_line) line_drop = 1'b1;
    end
    if (bus_reqcyc && bus_reqack) begin
      req_active = 1'b0;
      in_line    = 1'b1;
      rsp_q.push_back(bus_req);
      if (!line_drop) append_line(bus_req);
    end
    chk("respack", 64'(bus_respack), 64'(bus_respcyc));
    if (bus_respcyc && bus_respack) begin
      rsp_beat++;
      if (rsp_beat == BEATS) begin
        void'(rsp_q.pop_front());
        rsp_beat = 0;
        in_line  = 1'b0;
        if (!line_drop) m_pc = m_pc + 64'd64;
        line_drop = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic [63:0] e);
    @(negedge clk);
    reset = 1'b0;
    entry = e;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    q.delete(); rsp_q.delete(); req_log.delete(); pop_log.delete();
    rsp_beat = 0;
    m_pc = {e[63:6], 6'b0}; m_skip = e[5:2];
    m_halt = 0; line_drop = 0; in_line = 0; req_active = 0;
    ack_block = 0; trig_b3 = 0; rand_redir = 0; redir_now = 0;
    ready_mode = 1;
    zero_addr = 64'h1;
    #1;
    chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    chk("rst_req", bus_req, 64'd0);
    chk("rst_respack", 64'(bus_respack), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lo_cnt;
    reset = 1'b0;
    salt  = $urandom;

    // Aligned entry: one full line in order, then the next line
    do_reset(64'h1000);
    run(150);
    chk("t1_req0", at(req_log, 0), 64'h1000);
    chk("t1_pop0", at(pop_log, 0), 64'h1000);
    chk("t1_pop15", at(pop_log, 15), 64'h103C);
    chk("t1_req1", at(req_log, 1), 64'h1040);

    // Mid-line entry skips the first two words
    do_reset(64'h1008);
    run(150);
    chk("t2_req0", at(req_log, 0), 64'h1000);
    chk("t2_pop0", at(pop_log, 0), 64'h1008);
    lo_cnt = 0;
    foreach (pop_log[i]) if (pop_log[i] < 64'h1040) lo_cnt++;
    chk("t2_first_line_cnt", 64'(lo_cnt), 64'd14);

    // Zero word at index 5 halts the program
    do_reset(64'h3000);
    zero_addr = 64'h3014;
    run(200);
    chk("t3_pops", 64'(pop_log.size()), 64'd5);
    chk("t3_reqs", 64'(req_log.size()), 64'd1);
    chk("t3_halt", 64'(halt), 64'd1);

    // Back-pressure: two lines fill the FIFO, third waits for space
    do_reset(64'h4000);
    ready_mode = 0;
    run(200);
    chk("t4_reqs_stalled", 64'(req_log.size()), 64'd2);
    ready_mode = 1;
    run(200);
    chk("t4_req2", at(req_log, 2), 64'h4080);
    chk("t4_pop0", at(pop_log, 0), 64'h4000);
    chk("t4_pop31", at(pop_log, 31), 64'h407C);

    // Redirect during beat 3 of a line
    do_reset(64'h5000);
    ready_mode = 0;
    trig_b3 = 1'b1;
    trig_pc = 64'h2004;
    run(200);
    chk("t5_req0", at(req_log, 0), 64'h5000);
    chk("t5_req1", at(req_log, 1), 64'h2000);
    ready_mode = 1;
    run(60);
    chk("t5_pop0", at(pop_log, 0), 64'h2004);

    // Redirect while the request waits for ack
    do_reset(64'h6000);
    ack_block = 1'b1;
    for (int i = 0; i < 20 && req_log.size() == 0; i++) step();
    run(2);
    redir_now    = 1'b1;
    redir_pc_now = 64'h6100;
    run(2);
    ack_block = 1'b0;
    run(150);
    chk("t6_req0", at(req_log, 0), 64'h6000);
    chk("t6_req1", at(req_log, 1), 64'h6100);
    chk("t6_pop0", at(pop_log, 0), 64'h6100);

    // Fetch PC wraps at the top of the address space
    do_reset(64'hFFFF_FFFF_FFFF_FFC0);
    run(120);
    chk("t8_req0", at(req_log, 0), 64'hFFFF_FFFF_FFFF_FFC0);
    chk("t8_req1", at(req_log, 1), 64'h0);

    // Random traffic, back-pressure, redirects and halts
    do_reset(64'($urandom_range(0, 32'hFFFF)) << 2);
    ready_mode = 2;
    rand_redir = 1'b1;
    run(4000);
    rand_redir = 1'b0;
    ready_mode = 1;
    run(200);
    chk("t7_pops", 64'(pop_log.size() > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
